bird_motion: RTL and testbench

Vertical-motion engine for the bird sprite, sitting directly downstream of the one-pulse key stage. It consumes the single-cycle `flap` pulse, runs a fixed-rate physics step (gravity, flap impulse, ceiling clamp, ground death), and drives the bird's row index to the display/collision logic. It also runs the IDLE → FLY → DEAD game-state machine that the rest of the game keys off.

---
 rtl/bird_motion.sv | 149 ++++++++++++++
 tb/tb_bird_motion.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bird_motion.sv
// rtl/bird_motion.sv - bird vertical-motion physics and IDLE/FLY/DEAD game state
module bird_motion #(
  parameter int ROWS      = 16,
  parameter int TICK_DIV  = 256,
  parameter int FLAP_V    = 2,
  parameter int MAX_FALL  = 2,
  parameter int START_ROW = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flap,
  input  logic                    crash,
  output logic [$clog2(ROWS)-1:0] row,
  output logic                    alive,
  output logic                    dead,
  output logic                    step
);

  // Row index width, signed velocity width, and signed position width with
  // headroom so row+vel never wraps in either direction.
  localparam int RW = $clog2(ROWS);
  localparam int VW = RW + 1;
  localparam int PW = RW + 2;
  localparam int DW = $clog2(TICK_DIV);

  localparam logic signed [VW-1:0] V_FLAP   = VW'(-FLAP_V);
  localparam logic signed [VW-1:0] V_MAX    = VW'(MAX_FALL);
  localparam logic signed [VW-1:0] V_ONE    = VW'(1);
  localparam logic signed [VW-1:0] V_ZERO   = '0;
  localparam logic signed [PW-1:0] P_LAST   = PW'(ROWS - 1);
  localparam logic        [RW-1:0] R_START  = RW'(START_ROW);
  localparam logic        [RW-1:0] R_GROUND = RW'(ROWS - 1);
  localparam logic        [DW-1:0] D_LAST   = DW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    DEAD = 2'd2
  } state_t;

  state_t                 state;
  logic signed [VW-1:0]   vel;
  logic        [DW-1:0]   div;
  logic                   pend;

  logic                   tick_now;
  logic                   flap_due;
  logic signed [VW-1:0]   vel_next;
  logic signed [PW-1:0]   pos_next;
  logic                   hit_ceiling;
  logic                   hit_ground;

  // Physics step datapath: new velocity and the unclamped next position.
  always_comb begin
    tick_now    = (div == D_LAST);
    flap_due    = pend | flap;
    vel_next    = vel;
    pos_next    = '0;
    hit_ceiling = 1'b0;
    hit_ground  = 1'b0;
    if (flap_due) begin
      vel_next = V_FLAP;
    end else if (vel >= V_MAX) begin
      vel_next = V_MAX;
    end else begin
      vel_next = vel + V_ONE;
    end
    pos_next    = $signed({2'b00, row}) + $signed({vel_next[VW-1], vel_next});
    hit_ceiling = pos_next[PW-1];
    hit_ground  = !hit_ceiling && (pos_next > P_LAST);
  end

  // Game-state FSM with registered row, velocity, divider and outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      row   <= R_START;
      vel   <= V_ZERO;
      div   <= '0;
      pend  <= 1'b0;
      alive <= 1'b0;
      dead  <= 1'b0;
      step  <= 1'b0;
    end else begin
      step <= 1'b0;
      case (state)
        IDLE: begin
          row <= R_START;
          if (flap) begin
            state <= FLY;
            pend  <= 1'b1;
            div   <= '0;
            vel   <= V_ZERO;
            alive <= 1'b1;
            dead  <= 1'b0;
          end
        end
        FLY: begin
          if (crash) begin
            // A collision pre-empts any step landing in the same cycle.
            state <= DEAD;
            alive <= 1'b0;
            dead  <= 1'b1;
          end else if (tick_now) begin
            div  <= '0;
            pend <= 1'b0;
            step <= 1'b1;
            if (hit_ceiling) begin
              row <= '0;
              vel <= V_ZERO;
            end else if (hit_ground) begin
              row   <= R_GROUND;
              vel   <= vel_next;
              state <= DEAD;
              alive <= 1'b0;
              dead  <= 1'b1;
            end else begin
              row <= pos_next[RW-1:0];
              vel <= vel_next;
            end
          end else begin
            div  <= div + DW'(1);
            pend <= flap_due;
          end
        end
        DEAD: begin
          if (flap) begin
            state <= IDLE;
            row   <= R_START;
            vel   <= V_ZERO;
            pend  <= 1'b0;
            alive <= 1'b0;
            dead  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          row   <= R_START;
          vel   <= V_ZERO;
          div   <= '0;
          pend  <= 1'b0;
          alive <= 1'b0;
          dead  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bird_motion.sv
// tb/tb_bird_motion.sv - directed self-checking bench for bird_motion
module tb_bird_motion;

  logic       clk;
  logic       reset;
  logic       flap;
  logic       crash;
  logic [3:0] row;
  logic       alive;
  logic       dead;
  logic       step;

  int checks;
  int errors;

  bird_motion #(
    .ROWS      (16),
    .TICK_DIV  (4),
    .FLAP_V    (2),
    .MAX_FALL  (2),
    .START_ROW (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flap  (flap),
    .crash (crash),
    .row   (row),
    .alive (alive),
    .dead  (dead),
    .step  (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_flap();
    flap = 1'b1;
    tick();
    flap = 1'b0;
  endtask

  // Advance until step is seen; n is the cycle count, or -1 on timeout.
  task automatic wait_step(output int n);
    n = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (step === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b0;
    flap  = 1'b0;
    crash = 1'b0;
    #12;
    checks++;
    if (row !== 4'd8 || alive !== 1'b0 || dead !== 1'b0 || step !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: row=%0d alive=%b dead=%b step=%b, want row=8 0 0 0", row, alive, dead, step);
    end
    reset = 1'b1;
    tick();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (row !== 4'd8 || alive !== 1'b0 || dead !== 1'b0 || step !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_idle_hold: %0d cycles changed, want 0", bad);
    end
  endtask

  task automatic test_arc();
    int exp_rows [8] = '{6, 5, 5, 6, 8, 10, 12, 14};
    int n;
    pulse_flap();
    checks++;
    if (alive !== 1'b1 || dead !== 1'b0) begin
      errors++;
      $display("FAIL arc_start: alive=%b dead=%b, want 1 0", alive, dead);
    end
    for (int i = 0; i < 8; i++) begin
      wait_step(n);
      checks++;
      if (n != 4 || row !== 4'(exp_rows[i])) begin
        errors++;
        $display("FAIL arc_step%0d: cycles=%0d row=%0d, want cycles=4 row=%0d", i, n, row, exp_rows[i]);
      end
    end
  endtask

  task automatic test_ground_death();
    int n;
    int bad;
    wait_step(n);
    checks++;
    if (n != 4 || row !== 4'd15 || dead !== 1'b1 || alive !== 1'b0) begin
      errors++;
      $display("FAIL ground_hit: cycles=%0d row=%0d dead=%b alive=%b, want 4 15 1 0", n, row, dead, alive);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (row !== 4'd15 || step !== 1'b0 || dead !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ground_frozen: %0d cycles changed, want 0", bad);
    end
    pulse_flap();
    checks++;
    if (row !== 4'd8 || dead !== 1'b0 || alive !== 1'b0) begin
      errors++;
      $display("FAIL dead_to_idle: row=%0d dead=%b alive=%b, want 8 0 0", row, dead, alive);
    end
  endtask

  task automatic test_ceiling_merge();
    int n;
    pulse_flap();
    wait_step(n);
    wait_step(n);
    checks++;
    if (n != 4 || row !== 4'd5) begin
      errors++;
      $display("FAIL climb_a: cycles=%0d row=%0d, want 4 5", n, row);
    end
    pulse_flap();
    wait_step(n);
    checks++;
    if (n != 3 || row !== 4'd3) begin
      errors++;
      $display("FAIL climb_b: cycles=%0d row=%0d, want 3 3", n, row);
    end
    pulse_flap();
    wait_step(n);
    checks++;
    if (n != 3 || row !== 4'd1) begin
      errors++;
      $display("FAIL climb_c: cycles=%0d row=%0d, want 3 1", n, row);
    end
    pulse_flap();
    tick();
    pulse_flap();
    wait_step(n);
    checks++;
    if (n != 1 || row !== 4'd0 || alive !== 1'b1) begin
      errors++;
      $display("FAIL ceiling_clamp: cycles=%0d row=%0d alive=%b, want 1 0 1", n, row, alive);
    end
    wait_step(n);
    checks++;
    if (n != 4 || row !== 4'd1) begin
      errors++;
      $display("FAIL ceiling_fall: cycles=%0d row=%0d, want 4 1", n, row);
    end
  endtask

  task automatic test_crash_step();
    tick();
    tick();
    tick();
    crash = 1'b1;
    tick();
    crash = 1'b0;
    checks++;
    if (dead !== 1'b1 || alive !== 1'b0 || row !== 4'd1 || step !== 1'b0) begin
      errors++;
      $display("FAIL crash_vs_step: dead=%b alive=%b row=%0d step=%b, want 1 0 1 0", dead, alive, row, step);
    end
    pulse_flap();
    checks++;
    if (row !== 4'd8 || dead !== 1'b0 || alive !== 1'b0) begin
      errors++;
      $display("FAIL crash_to_idle: row=%0d dead=%b alive=%b, want 8 0 0", row, dead, alive);
    end
  endtask

  task automatic test_async_reset();
    int n;
    pulse_flap();
    wait_step(n);
    wait_step(n);
    checks++;
    if (row !== 4'd5 || alive !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: row=%0d alive=%b, want 5 1", row, alive);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (row !== 4'd8 || alive !== 1'b0 || dead !== 1'b0 || step !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: row=%0d alive=%b dead=%b step=%b, want 8 0 0 0", row, alive, dead, step);
    end
    #2;
    reset = 1'b1;
    tick();
    checks++;
    if (alive !== 1'b0 || row !== 4'd8) begin
      errors++;
      $display("FAIL post_reset_idle: alive=%b row=%0d, want 0 8", alive, row);
    end
    pulse_flap();
    wait_step(n);
    checks++;
    if (n != 4 || row !== 4'd6 || alive !== 1'b1) begin
      errors++;
      $display("FAIL restart_step: cycles=%0d row=%0d alive=%b, want 4 6 1", n, row, alive);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_arc();
    test_ground_death();
    test_ceiling_merge();
    test_crash_step();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
